// File: rtl/as_gpio_arb.sv
// as_gpio_arb: two-requester GPIO write arbiter (core store path vs. debug).
// A granted request is registered onto gpio_o/gpioAddr_o and qualified by a
// one-cycle cs_o strobe, followed by GAP_CYCLES forced idle cycles. Ties
// between simultaneous requesters are broken by a round-robin pointer.
module as_gpio_arb #(
    parameter int DW         = 8,
    parameter int AW         = 8,
    parameter int GAP_CYCLES = 2,   // 0..15
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,          // active-low, asynchronous
    input  logic             req0_valid_i,
    input  logic [AW-1:0]    req0_addr_i,
    input  logic [DW-1:0]    req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [AW-1:0]    req1_addr_i,
    input  logic [DW-1:0]    req1_data_i,
    output logic             req1_ready_o,
    output logic [DW-1:0]    gpio_o,
    output logic [AW-1:0]    gpioAddr_o,
    output logic             cs_o,
    output logic             owner_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] xfer_cnt_o
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [3:0]       GAP_LOAD = 4'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] gap_cnt;
    logic       rr_ptr;     // requester favoured on a tie (0 = req0)

    logic [1:0] vld;
    req_t       req [2];
    logic       sel;        // requester chosen this cycle
    logic       grant;      // a handshake completes on this edge
    req_t       sel_req;

    assign vld    = {req1_valid_i, req0_valid_i};
    assign req[0] = '{addr: req0_addr_i, data: req0_data_i};
    assign req[1] = '{addr: req1_addr_i, data: req1_data_i};

    // Pick the requester: a lone valid wins outright, a tie goes to rr_ptr.
    // Ready is held low under reset so nothing can be accepted mid-reset.
    always_comb begin
        sel     = 1'b0;
        grant   = 1'b0;
        sel_req = req[0];
        if (vld == 2'b11) sel = rr_ptr;
        else              sel = vld[1];
        sel_req = sel ? req[1] : req[0];
        grant   = (state == IDLE) && rst_i && (|vld);
    end

    assign req0_ready_o = grant && !sel;
    assign req1_ready_o = grant &&  sel;
    assign busy_o       = (state != IDLE);

    // Arbitration FSM: capture on grant, strobe for one cycle, then hold off
    // for GAP_CYCLES before the next grant can be made.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            gap_cnt    <= 4'd0;
            rr_ptr     <= 1'b0;
            cs_o       <= 1'b0;
            gpio_o     <= '0;
            gpioAddr_o <= '0;
            owner_o    <= 1'b0;
            xfer_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        gpio_o     <= sel_req.data;
                        gpioAddr_o <= sel_req.addr;
                        owner_o    <= sel;
                        rr_ptr     <= ~sel;   // favour the other side next tie
                        cs_o       <= 1'b1;
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    cs_o       <= 1'b0;
                    xfer_cnt_o <= xfer_cnt_o + CNT_ONE;
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // Count ends on 1 so exactly GAP_CYCLES cycles are spent here.
                    if (gap_cnt <= 4'd1) begin
                        gap_cnt <= 4'd0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    cs_o  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_as_gpio_arb.sv
// tb_as_gpio_arb: scoreboard bench for as_gpio_arb, run on two configurations
// (GAP_CYCLES=2/CNT_W=16 and GAP_CYCLES=0/CNT_W=4). The stimulus side owns a
// cycle-level model (next legal accept cycle, tie pointer) and pushes each
// predicted strobe; the monitor pops when cs_o is seen and compares.
module tb_as_gpio_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit done [2];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         owner;
        int         cyc;     // cycle in which cs_o must be high
    } exp_t;

    function automatic void chk(input int cfg, input string name,
                                input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL cfg%0d %s: got %0d, expected %0d", cfg, name, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int GAP = (g == 0) ? 2 : 0;
        localparam int CW  = (g == 0) ? 16 : 4;

        logic          rst_n;
        logic          v0, v1, r0, r1;
        logic [7:0]    a0, a1, d0, d1;
        logic [7:0]    gpio, gaddr;
        logic          cs, owner, busy;
        logic [CW-1:0] cnt;

        as_gpio_arb #(.DW(8), .AW(8), .GAP_CYCLES(GAP), .CNT_W(CW)) u_dut (
            .clk_i(clk), .rst_i(rst_n),
            .req0_valid_i(v0), .req0_addr_i(a0), .req0_data_i(d0), .req0_ready_o(r0),
            .req1_valid_i(v1), .req1_addr_i(a1), .req1_data_i(d1), .req1_ready_o(r1),
            .gpio_o(gpio), .gpioAddr_o(gaddr), .cs_o(cs), .owner_o(owner),
            .busy_o(busy), .xfer_cnt_o(cnt)
        );

        // Reference model state
        int   cyc = 0;
        exp_t q[$];
        bit   ptr = 1'b0;
        int   next_ok = 0, busy_from = -1, busy_to = -2;
        int   pushed = 0, last_strobe = -1;
        logic [7:0] last_d = '0, last_a = '0;
        bit   last_o = 1'b0;
        bit   acc0, acc1, mon_en = 1'b0, prev_cs = 1'b0;
        bit   own_log[$];

        function automatic void model_reset();
            q.delete();
            ptr = 1'b0; next_ok = 0; busy_from = -1; busy_to = -2;
            pushed = 0; last_strobe = -1;
            last_d = '0; last_a = '0; last_o = 1'b0;
        endfunction

        task automatic tick();
            @(posedge clk); cyc++; #1;
        endtask

        // One cycle: predict the handshake for the coming edge, check ready.
        task automatic step();
            bit idle_m, sel, any;
            #1;
            any    = v0 | v1;
            idle_m = rst_n && (cyc >= next_ok);
            sel    = (v0 && v1) ? ptr : v1;
            acc0 = 1'b0; acc1 = 1'b0;
            chk(g, "ready0", r0, idle_m && any && !sel);
            chk(g, "ready1", r1, idle_m && any && sel);
            if (idle_m && any) begin
                q.push_back('{sel ? a1 : a0, sel ? d1 : d0, sel, cyc + 1});
                pushed++;
                last_strobe = cyc + 1;
                busy_from   = cyc + 1;
                busy_to     = cyc + 1 + GAP;
                next_ok     = cyc + 2 + GAP;
                ptr         = !sel;
                if (sel) acc1 = 1'b1; else acc0 = 1'b1;
            end
            @(posedge clk); cyc++; #1;
        endtask

        task automatic run_xfers(input bit en0, input bit en1, input int n);
            int got = 0;
            int budget = n * (GAP + 2) + 20;
            v0 = en0; v1 = en1;
            while (got < n && budget > 0) begin
                step(); budget--;
                if (acc0) begin got++; a0 = 8'($urandom); d0 = 8'($urandom); end
                if (acc1) begin got++; a1 = 8'($urandom); d1 = 8'($urandom); end
            end
            if (got < n) chk(g, "xfer_timeout", got, n);
            v0 = 1'b0; v1 = 1'b0;
            repeat (GAP + 2) step();
        endtask

        task automatic do_reset(input int n);
            rst_n = 1'b0; #1;
            model_reset();
            repeat (n) begin
                chk(g, "rst_ready0", r0, 0);
                chk(g, "rst_ready1", r1, 0);
                tick();
            end
            rst_n = 1'b1;
        endtask

        // Monitor: pop the prediction whenever the DUT strobes.
        always @(negedge clk) begin
            exp_t e;
            int   ec;
            if (mon_en && rst_n) begin
                ec = pushed - ((last_strobe >= cyc) ? 1 : 0);
                chk(g, "xfer_cnt", cnt, ec & ((1 << CW) - 1));
                chk(g, "busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
                if (cs) begin
                    chk(g, "cs_back_to_back", prev_cs, 0);
                    own_log.push_back(owner);
                    if (q.size() == 0) begin
                        chk(g, "spurious_cs", cs, 0);
                    end else begin
                        e = q.pop_front();
                        chk(g, "cs_cycle", cyc, e.cyc);
                        chk(g, "gpio_addr", gaddr, e.addr);
                        chk(g, "gpio_data", gpio, e.data);
                        chk(g, "owner", owner, e.owner);
                        last_a = e.addr; last_d = e.data; last_o = e.owner;
                    end
                end else begin
                    if (q.size() != 0 && q[0].cyc <= cyc) begin
                        chk(g, "cs_missing", cs, 1);
                        e = q.pop_front();
                        last_a = e.addr; last_d = e.data; last_o = e.owner;
                    end
                    chk(g, "hold_addr", gaddr, last_a);
                    chk(g, "hold_data", gpio, last_d);
                    chk(g, "hold_owner", owner, last_o);
                end
                prev_cs = cs;
            end else begin
                prev_cs = 1'b0;
            end
        end

        initial begin
            // Reset held 10 cycles with both requesters asking
            rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1;
            a0 = 8'($urandom); d0 = 8'($urandom); a1 = 8'($urandom); d1 = 8'($urandom);
            model_reset();
            repeat (10) begin
                @(negedge clk);
                chk(g, "rst_r0", r0, 0);     chk(g, "rst_r1", r1, 0);
                chk(g, "rst_cs", cs, 0);     chk(g, "rst_gpio", gpio, 0);
                chk(g, "rst_addr", gaddr, 0); chk(g, "rst_owner", owner, 0);
                chk(g, "rst_busy", busy, 0); chk(g, "rst_cnt", cnt, 0);
            end
            tick();
            rst_n = 1'b1; v0 = 1'b0; v1 = 1'b0; mon_en = 1'b1;

            // Single req0 transfer, addr 4 data 0x1D
            a0 = 8'd4; d0 = 8'h1D;
            run_xfers(1'b1, 1'b0, 1);
            chk(g, "cnt_after_first", cnt, 1);

            // Reset in the middle of a strobe
            a0 = 8'($urandom); d0 = 8'($urandom); v0 = 1'b1;
            step();
            v0 = 1'b0;
            chk(g, "cs_in_strobe", cs, 1);
            rst_n = 1'b0; #1;
            chk(g, "cs_cleared_by_rst", cs, 0);
            chk(g, "cnt_cleared_by_rst", cnt, 0);
            v0 = 1'b1; v1 = 1'b1;
            do_reset(3);

            // Both valid continuously: strict alternation starting at req0
            own_log.delete();
            run_xfers(1'b1, 1'b1, 6);
            chk(g, "owner_seq_len", own_log.size(), 6);
            for (int i = 0; i < 6 && i < own_log.size(); i++)
                chk(g, "owner_seq", own_log[i], i % 2);

            // Lone req1 is granted even when the pointer favours req0
            run_xfers(1'b0, 1'b1, 3);
            chk(g, "owner_req1", owner, 1);

            // Counter wrap: 17 transfers from a fresh reset
            v0 = 1'b0; v1 = 1'b0;
            do_reset(2);
            run_xfers(1'b1, 1'b0, 17);
            chk(g, "cnt_wrap_end", cnt, 17 & ((1 << CW) - 1));

            // Randomized traffic including valid withdrawn without handshake
            for (int i = 0; i < 400; i++) begin
                if (acc0 || !v0) begin
                    v0 = ($urandom % 3) != 0; a0 = 8'($urandom); d0 = 8'($urandom);
                end else if ($urandom % 16 == 0) begin
                    v0 = 1'b0;
                end
                if (acc1 || !v1) begin
                    v1 = ($urandom % 3) != 0; a1 = 8'($urandom); d1 = 8'($urandom);
                end else if ($urandom % 16 == 0) begin
                    v1 = 1'b0;
                end
                step();
            end
            v0 = 1'b0; v1 = 1'b0;
            repeat (GAP + 3) step();
            chk(g, "queue_drained", q.size(), 0);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(done[0] && done[1]); i++) @(posedge clk);
        if (!(done[0] && done[1])) begin
            checks++;
            failures++;
            $display("FAIL watchdog: done=%0d%0d, expected 11", done[0], done[1]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
